compare_scoreboard: RTL



---
 rtl/compare_pkg.sv | 32 +++
 rtl/compare_fail_fifo.sv | 68 ++++++
 rtl/compare_scoreboard.sv | 126 ++++++++++++
 3 files changed

// File: rtl/compare_pkg.sv
//------------------------------------------------------------------------------
// Module   : compare_pkg
// Brief    : Shared constants and fail-record layout for the compare scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package compare_pkg;

    localparam int NGROUPS = 9;
    localparam int IDX_W   = 17;

    localparam int A_GRP = 0;
    localparam int B_GRP = 1;
    localparam int C_GRP = 2;
    localparam int D_GRP = 3;
    localparam int E_GRP = 4;
    localparam int F_GRP = 5;
    localparam int G_GRP = 6;
    localparam int H_GRP = 7;
    localparam int I_GRP = 8;

    typedef struct packed {
        logic [3:0]         in1;
        logic [3:0]         in2;
        logic [NGROUPS-1:0] failmask;
        logic [IDX_W-1:0]   index;
    } fail_rec_t;

endpackage

`default_nettype wire

// File: rtl/compare_fail_fifo.sv
//------------------------------------------------------------------------------
// Module   : compare_fail_fifo
// Brief    : Circular-buffer record FIFO with explicit occupancy count.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module compare_fail_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full
);

    localparam int            c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0] c_depth = (c_aw+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_pop  = i_pop & (r_count != '0);
    assign w_do_push = i_push & ((r_count != c_depth) | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_aw+1)'(1);
                2'b01:   r_count <= r_count - (c_aw+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == c_depth);

endmodule

`default_nettype wire

// File: rtl/compare_scoreboard.sv
//------------------------------------------------------------------------------
// Module   : compare_scoreboard
// Brief    : Two-stage spec/impl compare pipeline with counters and fail FIFO.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module compare_scoreboard
    import compare_pkg::fail_rec_t;
#(
    parameter int NGROUPS = 9,
    parameter int DEPTH   = 8,
    parameter int TOTAL   = 65536
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [NGROUPS-1:0] group_mask,
    input  logic               sample_valid,
    input  logic [3:0]         sample_in1,
    input  logic [3:0]         sample_in2,
    input  logic [NGROUPS-1:0] group_ok,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [3:0]         rec_in1,
    output logic [3:0]         rec_in2,
    output logic [NGROUPS-1:0] rec_failmask,
    output logic [16:0]        rec_index,
    output logic [16:0]        sample_count,
    output logic [16:0]        fail_count,
    output logic [7:0]         drop_count,
    output logic               done
);

    localparam logic [16:0] c_total = 17'(TOTAL);

    logic [NGROUPS-1:0] w_failmask;
    logic               w_accept;
    logic               w_s1_fail;
    logic               w_pop;
    logic               w_push;
    logic               w_fifo_full;
    logic               w_fifo_rst;
    fail_rec_t          w_push_rec;
    fail_rec_t          w_head_rec;

    logic               r_s1_valid;
    logic [3:0]         r_s1_in1;
    logic [3:0]         r_s1_in2;
    logic [NGROUPS-1:0] r_s1_failmask;
    logic [16:0]        r_s1_index;
    logic [16:0]        r_sample_count;
    logic [16:0]        r_fail_count;
    logic [7:0]         r_drop_count;

    // Anything other than a solid 1 on an ok flag (0, X or Z) is a failure.
    generate
        for (genvar g = 0; g < NGROUPS; g++) begin : g_failmask
            assign w_failmask[g] = group_mask[g] & (group_ok[g] !== 1'b1);
        end
    endgenerate

    assign w_accept   = sample_valid & (r_sample_count != c_total);
    assign w_s1_fail  = r_s1_valid & (|r_s1_failmask);
    assign w_pop      = rec_valid & rec_ready;
    assign w_push     = w_s1_fail & (~w_fifo_full | w_pop);
    assign w_fifo_rst = reset | clear;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_s1_valid     <= 1'b0;
            r_sample_count <= '0;
            r_fail_count   <= '0;
            r_drop_count   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_in1       <= sample_in1;
                r_s1_in2       <= sample_in2;
                r_s1_failmask  <= w_failmask;
                r_s1_index     <= r_sample_count;
                r_sample_count <= r_sample_count + 17'd1;
            end
            if (w_s1_fail) begin
                r_fail_count <= r_fail_count + 17'd1;
                if (!w_push && (r_drop_count != 8'hFF)) begin
                    r_drop_count <= r_drop_count + 8'd1;
                end
            end
        end
    end

    always_comb begin
        w_push_rec          = '0;
        w_push_rec.in1      = r_s1_in1;
        w_push_rec.in2      = r_s1_in2;
        w_push_rec.failmask = r_s1_failmask;
        w_push_rec.index    = r_s1_index;
    end

    compare_fail_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fail_rec_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (w_fifo_rst),
        .i_push  (w_push),
        .i_data  (w_push_rec),
        .i_pop   (w_pop),
        .o_data  (w_head_rec),
        .o_valid (rec_valid),
        .o_full  (w_fifo_full)
    );

    assign rec_in1      = w_head_rec.in1;
    assign rec_in2      = w_head_rec.in2;
    assign rec_failmask = w_head_rec.failmask;
    assign rec_index    = w_head_rec.index;
    assign sample_count = r_sample_count;
    assign fail_count   = r_fail_count;
    assign drop_count   = r_drop_count;
    assign done         = (r_sample_count == c_total) & ~rec_valid;

endmodule

`default_nettype wire
